// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word-organised SRAM. Serves one transaction at a time, supports
// INCR bursts (always word increments), WSTRB byte lanes, ID echo, SLVERR outside the window
// and a fixed response latency between address/last-data acceptance and the response.
module axi4_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned ID_W      = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,    // active-low, asynchronous
  // write address
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [31:0]     i_awaddr,
  input  logic [ID_W-1:0] i_awid,
  input  logic [7:0]      i_awlen,
  input  logic [2:0]      i_awsize,
  input  logic [1:0]      i_awburst,
  // write data
  input  logic            i_wvalid,
  output logic            o_wready,
  input  logic [31:0]     i_wdata,
  input  logic [3:0]      i_wstrb,
  input  logic            i_wlast,
  // write response
  output logic            o_bvalid,
  input  logic            i_bready,
  output logic [1:0]      o_bresp,
  output logic [ID_W-1:0] o_bid,
  // read address
  input  logic            i_arvalid,
  output logic            o_arready,
  input  logic [31:0]     i_araddr,
  input  logic [ID_W-1:0] i_arid,
  input  logic [7:0]      i_arlen,
  input  logic [2:0]      i_arsize,
  input  logic [1:0]      i_arburst,
  // read data
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [31:0]     o_rdata,
  output logic [1:0]      o_rresp,
  output logic [ID_W-1:0] o_rid,
  output logic            o_rlast
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    StIdle, StRLat, StRData, StWData, StWLat, StWResp
  } state_e;

  state_e          r_state;
  logic            r_prio_w;
  logic [31:0]     r_addr;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_len;
  logic [7:0]      r_beat;
  logic [3:0]      r_lat;
  logic            r_err;
  logic            r_bvalid;
  logic [1:0]      r_bresp;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic [1:0]      r_rresp;
  logic            r_rlast;
  logic [31:0]     r_mem [DEPTH];

  logic            w_idle;
  logic            w_ar_acc;
  logic            w_aw_acc;
  logic            w_wr_beat;
  logic            w_wr_in;
  logic            w_wr_err;
  logic [31:0]     w_rd_addr;
  logic            w_rd_in;
  logic [31:0]     w_rd_word;
  logic [1:0]      w_rd_resp;
  logic            w_unused;

  function automatic logic f_in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < DEPTH);
  endfunction

  function automatic logic [IdxW-1:0] f_idx(input logic [31:0] a);
    return IdxW'((a - BASE_ADDR) >> 2);
  endfunction

  // Burst type and size are not decoded: every burst is a word-sized INCR.
  assign w_unused = ^{i_awsize, i_awburst, i_arsize, i_arburst};

  // Handshake readies are forced low while reset is asserted.
  assign w_idle    = (r_state == StIdle) && i_reset;
  assign o_arready = w_idle && i_arvalid && !(i_awvalid && r_prio_w);
  assign o_awready = w_idle && i_awvalid && !(i_arvalid && !r_prio_w);
  assign o_wready  = (r_state == StWData) && i_reset;
  assign w_ar_acc  = o_arready;
  assign w_aw_acc  = o_awready;

  assign w_wr_beat = o_wready && i_wvalid;
  assign w_wr_in   = f_in_range(r_addr);
  // Error if out of window, wlast early/late against awlen.
  assign w_wr_err  = !w_wr_in || (i_wlast ? (r_beat != r_len) : (r_beat == r_len));

  // Select the address whose word is loaded into the read data register next.
  always_comb begin
    w_rd_addr = r_addr;
    if (r_state == StIdle) begin
      w_rd_addr = i_araddr;
    end else if (r_state == StRData) begin
      w_rd_addr = r_addr + 32'd4;
    end
  end

  assign w_rd_in   = f_in_range(w_rd_addr);
  assign w_rd_word = w_rd_in ? r_mem[f_idx(w_rd_addr)] : 32'd0;
  assign w_rd_resp = w_rd_in ? 2'b00 : 2'b10;

  // SRAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge i_clock) begin
    if (w_wr_beat && w_wr_in) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wstrb[i]) r_mem[f_idx(r_addr)][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered response channel outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= StIdle;
      r_prio_w <= 1'b0;
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_lat    <= '0;
      r_err    <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_rlast  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_ar_acc) begin
            r_addr   <= i_araddr;
            r_id     <= i_arid;
            r_len    <= i_arlen;
            r_beat   <= '0;
            r_lat    <= 4'(LATENCY);
            r_err    <= 1'b0;
            r_prio_w <= ~r_prio_w;
            if (LATENCY == 0) begin
              r_state  <= StRData;
              r_rvalid <= 1'b1;
              r_rdata  <= w_rd_word;
              r_rresp  <= w_rd_resp;
              r_rlast  <= (i_arlen == 8'd0);
            end else begin
              r_state <= StRLat;
            end
          end else if (w_aw_acc) begin
            r_addr   <= i_awaddr;
            r_id     <= i_awid;
            r_len    <= i_awlen;
            r_beat   <= '0;
            r_lat    <= 4'(LATENCY);
            r_err    <= 1'b0;
            r_prio_w <= ~r_prio_w;
            r_state  <= StWData;
          end
        end
        StRLat: begin
          if (r_lat == 4'd1) begin
            r_state  <= StRData;
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word;
            r_rresp  <= w_rd_resp;
            r_rlast  <= (r_len == 8'd0);
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        StRData: begin
          if (i_rready) begin
            if (r_rlast) begin
              r_state  <= StIdle;
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_addr  <= r_addr + 32'd4;
              r_rdata <= w_rd_word;
              r_rresp <= w_rd_resp;
              r_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        StWData: begin
          if (i_wvalid) begin
            r_addr <= r_addr + 32'd4;
            r_beat <= r_beat + 8'd1;
            r_err  <= r_err | w_wr_err;
            if (i_wlast) begin
              if (LATENCY == 0) begin
                r_state  <= StWResp;
                r_bvalid <= 1'b1;
                r_bresp  <= (r_err || w_wr_err) ? 2'b10 : 2'b00;
              end else begin
                r_state <= StWLat;
              end
            end
          end
        end
        StWLat: begin
          if (r_lat == 4'd1) begin
            r_state  <= StWResp;
            r_bvalid <= 1'b1;
            r_bresp  <= r_err ? 2'b10 : 2'b00;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        StWResp: begin
          if (i_bready) begin
            r_state  <= StIdle;
            r_bvalid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;
  assign o_bid    = r_id;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_rresp  = r_rresp;
  assign o_rid    = r_id;
  assign o_rlast  = r_rlast;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: expected R beats and B responses are queued as stimulus
// is issued; a negedge monitor compares whatever the slave presents against the queue heads.
module tb_axi4_sram_slave;
  localparam int unsigned Lat = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic        wvalid = 1'b0, wready, wlast = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic        rvalid, rready = 1'b1, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;

  axi4_sram_slave #(
    .BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(Lat), .ID_W(4)
  ) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr), .i_awid(awid),
    .i_awlen(awlen), .i_awsize(3'd2), .i_awburst(2'b01),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp), .o_bid(bid),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr), .i_arid(arid),
    .i_arlen(arlen), .i_arsize(3'd2), .i_arburst(2'b01),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp), .o_rid(rid),
    .o_rlast(rlast)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;
  } r_exp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned aw_cyc = 0;
  int unsigned b_cyc = 0;
  logic        rtoggle = 1'b0;

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=timeout exp=handshake", name);
  endfunction

  // Monitor: compare presented R/B against queue heads; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected got=rvalid id=%h data=%h exp=idle", rid, rdata);
        end else begin
          check("r_beat", {rid, rdata, rresp, rlast}, rq[0]);
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected got=bvalid id=%h exp=idle", bid);
        end else begin
          check("b_resp", {bid, bresp}, bq[0]);
          if (bready) begin
            b_cyc = cyc;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  // rready is either held high or toggled every cycle.
  initial forever begin
    @(posedge clk); #1;
    rready = rtoggle ? ~rready : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) at negedges for: 0 awready, 1 wready, 2 arready, 3 either address ready.
  task automatic wait_cond(input int sel, input string name);
    int n;
    logic c;
    n = 0;
    forever begin
      @(negedge clk);
      case (sel)
        0: c = awready;
        1: c = wready;
        2: c = arready;
        default: c = arready | awready;
      endcase
      if (c) break;
      n++;
      if (n > 60) begin
        fail_now(name);
        break;
      end
    end
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
    rq.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input int nbeats, input logic [31:0] d0, input logic [3:0] strb,
                          input logic [1:0] resp);
    bq.push_back('{id: id, resp: resp});
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len;
    wvalid = 1'b1; wdata = d0; wstrb = strb; wlast = (nbeats == 1);
    wait_cond(0, "aw_timeout");
    tick();
    aw_cyc = cyc;
    awvalid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      wdata = d0 + 32'(k); wlast = (k == nbeats - 1); wvalid = 1'b1;
      wait_cond(1, "w_timeout");
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len;
    wait_cond(2, "ar_timeout");
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      fail_now("drain_timeout");
      rq.delete();
      bq.delete();
    end
    tick();
  endtask

  initial begin
    // Reset: outputs quiet even with both address valids raised.
    rst_n = 1'b0; arvalid = 1'b1; awvalid = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {awready, arready, wready, bvalid, rvalid, rlast, rresp, bresp,
                            rid, bid, rdata}, 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; rst_n = 1'b1;
    tick();

    // 1: full-word write, response Lat+1 cycles after AW acceptance.
    do_write(32'h8000_0000, 4'd3, 8'd0, 1, 32'hDEAD_BEEF, 4'hF, 2'b00);
    wait_drain();
    check("t1_latency", 64'(b_cyc - aw_cyc), 64'(Lat + 1));

    // 2: single byte lane write then read back.
    do_write(32'h8000_0000, 4'd1, 8'd0, 1, 32'h00AB_0000, 4'b0100, 2'b00);
    wait_drain();
    push_r(4'd5, 32'hDEAB_BEEF, 2'b00, 1'b1);
    do_read(32'h8000_0000, 4'd5, 8'd0);
    wait_drain();

    // 3: 4-beat burst write, then burst read with rready toggling.
    do_write(32'h8000_0010, 4'd2, 8'd3, 4, 32'h1000_0004, 4'hF, 2'b00);
    wait_drain();
    push_r(4'd6, 32'h1000_0004, 2'b00, 1'b0);
    push_r(4'd6, 32'h1000_0005, 2'b00, 1'b0);
    push_r(4'd6, 32'h1000_0006, 2'b00, 1'b0);
    push_r(4'd6, 32'h1000_0007, 2'b00, 1'b1);
    rtoggle = 1'b1;
    do_read(32'h8000_0010, 4'd6, 8'd3);
    wait_drain();
    rtoggle = 1'b0;
    tick();

    // 4: out-of-window read and write; word 0 must be untouched.
    push_r(4'd7, 32'h0, 2'b10, 1'b1);
    do_read(32'h7FFF_FFFC, 4'd7, 8'd0);
    wait_drain();
    do_write(32'h8000_1000, 4'd8, 8'd0, 1, 32'h1234_5678, 4'hF, 2'b10);
    wait_drain();
    push_r(4'd9, 32'hDEAB_BEEF, 2'b00, 1'b1);
    do_read(32'h8000_0000, 4'd9, 8'd0);
    wait_drain();

    // Burst crossing the window end: second beat errors.
    do_write(32'h8000_0FFC, 4'd10, 8'd0, 1, 32'h5555_AAAA, 4'hF, 2'b00);
    wait_drain();
    push_r(4'd11, 32'h5555_AAAA, 2'b00, 1'b0);
    push_r(4'd11, 32'h0, 2'b10, 1'b1);
    do_read(32'h8000_0FFC, 4'd11, 8'd1);
    wait_drain();

    // Early wlast against awlen=1 yields SLVERR.
    do_write(32'h8000_0040, 4'd12, 8'd1, 1, 32'h0F0F_0F0F, 4'hF, 2'b10);
    wait_drain();

    // W without AW is not accepted.
    wvalid = 1'b1; wlast = 1'b1;
    @(negedge clk);
    check("wready_idle", 64'(wready), 64'd0);
    tick();
    wvalid = 1'b0; wlast = 1'b0;

    do_write(32'h8000_0020, 4'd13, 8'd0, 1, 32'h0808_0808, 4'hF, 2'b00);
    wait_drain();

    // 6: reset during read latency aborts the read.
    arvalid = 1'b1; araddr = 32'h8000_0000; arid = 4'd14; arlen = 8'd0;
    wait_cond(2, "t6_ar_timeout");
    tick();
    tick();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_in_reset", {arready, awready, rvalid, bvalid}, 64'd0);
    end
    @(posedge clk); #1;
    arvalid = 1'b0; rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("t6_no_rvalid", 64'(rvalid), 64'd0);
    end
    tick();
    push_r(4'd15, 32'hDEAB_BEEF, 2'b00, 1'b1);
    do_read(32'h8000_0000, 4'd15, 8'd0);
    wait_drain();

    // 5: two ties in a row after reset: read first, then write; reads bracket the write.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push_r(4'd1, 32'h0808_0808, 2'b00, 1'b1);
    bq.push_back('{id: 4'd2, resp: 2'b00});
    push_r(4'd1, 32'hC0FF_EE00, 2'b00, 1'b1);
    arvalid = 1'b1; araddr = 32'h8000_0020; arid = 4'd1; arlen = 8'd0;
    awvalid = 1'b1; awaddr = 32'h8000_0020; awid = 4'd2; awlen = 8'd0;
    wait_cond(3, "t5_tie1_timeout");
    check("t5_tie1", 64'({arready, awready}), 64'b10);
    tick();
    wait_cond(3, "t5_tie2_timeout");
    check("t5_tie2", 64'({arready, awready}), 64'b01);
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hC0FF_EE00; wstrb = 4'hF; wlast = 1'b1;
    wait_cond(1, "t5_w_timeout");
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    wait_cond(2, "t5_ar2_timeout");
    tick();
    arvalid = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
